// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    TIMEOUT = 2'b10
  } mem_fsm_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RES_SRC_LOAD = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage RV32I pipeline, with a
// memory-wait FSM, timeout watchdog and saturating performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned MAX_WAIT               = 15,
  parameter int unsigned CNT_WIDTH              = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic                              RegWriteM_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteW_i,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic                              MemTimeout_o,
  output logic [CNT_WIDTH-1:0]              StallCycles_o,
  output logic [CNT_WIDTH-1:0]              FlushCount_o
);

  localparam int unsigned WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  mem_fsm_t       state, state_n;
  logic [WCW-1:0] wait_cnt, wait_cnt_n;
  fwd_sel_t       fwd_a, fwd_b;
  logic           lw_stall;
  logic           mem_stall;
  logic           flush_inc;

  // Forwarding: Memory-stage result wins over Writeback; x0 is never forwarded.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst_i) begin
      if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs1E_i)) begin
        fwd_a = FWD_M;
      end else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs1E_i)) begin
        fwd_a = FWD_W;
      end
      if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs2E_i)) begin
        fwd_b = FWD_M;
      end else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs2E_i)) begin
        fwd_b = FWD_W;
      end
    end
  end

  assign ForwardAE_o = fwd_a;
  assign ForwardBE_o = fwd_b;

  assign lw_stall = (ResultSrcE_i == RES_SRC_LOAD) && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = MemReqM_i && !MemReadyM_i;
      WAIT:    mem_stall = !MemReadyM_i;
      TIMEOUT: mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      IDLE: begin
        if (MemReqM_i && !MemReadyM_i) begin
          state_n    = WAIT;
          wait_cnt_n = WCW'(1);
        end
      end
      WAIT: begin
        if (MemReadyM_i) begin
          state_n = IDLE;
        end else if (wait_cnt == WCW'(MAX_WAIT)) begin
          state_n = TIMEOUT;
        end else begin
          wait_cnt_n = wait_cnt + WCW'(1);
        end
      end
      TIMEOUT: state_n = TIMEOUT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  assign MemTimeout_o = (state == TIMEOUT);

  // A memory stall holds Execute, so a pending branch or load-use re-presents after release.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (rst_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (mem_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (PCSrcE_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (lw_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  assign flush_inc = !rst_i && !mem_stall && PCSrcE_i;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (StallF_o),
    .count_o (StallCycles_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_inc),
    .count_o (FlushCount_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand-built multi-cycle sequences.
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0]    rsrc;
  logic          pcsrc, rwm, rww, req, rdy;
  logic [1:0]    fa, fb;
  logic          stf, std, ste, stm, fld, fle, flw, tmo;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(
    .REGISTER_ADDRESS_WIDTH(5),
    .MAX_WAIT(15),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e), .RdE_i(rde),
    .ResultSrcE_i(rsrc), .PCSrcE_i(pcsrc),
    .RdM_i(rdm), .RegWriteM_i(rwm), .MemReqM_i(req), .MemReadyM_i(rdy),
    .RdW_i(rdw), .RegWriteW_i(rww),
    .ForwardAE_o(fa), .ForwardBE_o(fb),
    .StallF_o(stf), .StallD_o(std), .StallE_o(ste), .StallM_o(stm),
    .FlushD_o(fld), .FlushE_o(fle), .FlushW_o(flw),
    .MemTimeout_o(tmo), .StallCycles_o(stall_cnt), .FlushCount_o(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [4:0] rdm;
    logic       rwm;
    logic [4:0] rdw;
    logic       rww, req, rdy;
    logic [1:0] fa, fb;
    logic [3:0] stall;  // {F,D,E,M}
    logic [2:0] flush;  // {D,E,W}
    logic       tmo;
  } vec_t;

  vec_t          sb[$];
  vec_t          tbl[17];
  int            checks = 0;
  int            errors = 0;
  int unsigned   exp_sc = 0;
  int unsigned   exp_fc = 0;
  bit            cnt_valid = 0;

  function automatic vec_t mkv(
    input logic r, input logic [4:0] a1d, a2d, a1e, a2e, ade,
    input logic [1:0] src, input logic pc,
    input logic [4:0] am, input logic wm, input logic [4:0] aw, input logic ww,
    input logic rq, input logic rd,
    input logic [1:0] efa, efb, input logic [3:0] est, input logic [2:0] efl,
    input logic etmo);
    vec_t v;
    v.rst = r; v.rs1d = a1d; v.rs2d = a2d; v.rs1e = a1e; v.rs2e = a2e; v.rde = ade;
    v.rsrc = src; v.pcsrc = pc; v.rdm = am; v.rwm = wm; v.rdw = aw; v.rww = ww;
    v.req = rq; v.rdy = rd;
    v.fa = efa; v.fb = efb; v.stall = est; v.flush = efl; v.tmo = etmo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_head();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk("fwd_a", {30'd0, fa}, {30'd0, e.fa});
    chk("fwd_b", {30'd0, fb}, {30'd0, e.fb});
    chk("stall", {28'd0, stf, std, ste, stm}, {28'd0, e.stall});
    chk("flush", {29'd0, fld, fle, flw}, {29'd0, e.flush});
    chk("timeout", {31'd0, tmo}, {31'd0, e.tmo});
    if (cnt_valid) begin
      chk("stall_cycles", {{(32-CW){1'b0}}, stall_cnt}, exp_sc);
      chk("flush_count", {{(32-CW){1'b0}}, flush_cnt}, exp_fc);
    end
    if (e.rst) begin
      exp_sc = 0;
      exp_fc = 0;
      cnt_valid = 1;
    end else begin
      if (e.stall[3] && exp_sc < (2**CW - 1)) exp_sc++;
      if (e.pcsrc && e.stall == 4'b0000 && exp_fc < (2**CW - 1)) exp_fc++;
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e;
    rde = v.rde; rsrc = v.rsrc; pcsrc = v.pcsrc; rdm = v.rdm; rwm = v.rwm;
    rdw = v.rdw; rww = v.rww; req = v.req; rdy = v.rdy;
    sb.push_back(v);
    @(negedge clk);
    compare_head();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    vec_t idle, mstall, tstall;
    rst = 1'b1; rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rsrc = '0;
    pcsrc = 1'b0; rdm = '0; rwm = 1'b0; rdw = '0; rww = 1'b0; req = 1'b0; rdy = 1'b0;

    //             rst rs1d rs2d rs1e rs2e rde rsrc  pc rdm rwm rdw rww req rdy  fa     fb     stall    flush   tmo
    tbl[0]  = mkv(1, 0, 3, 5, 0, 3, 2'b01, 0, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b111, 0);
    tbl[1]  = mkv(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b111, 0);
    tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 0);
    tbl[3]  = mkv(0, 0, 0, 5, 0, 0, 2'b00, 0, 5, 1, 5, 1, 0, 0, 2'b10, 2'b00, 4'b0000, 3'b000, 0);
    tbl[4]  = mkv(0, 0, 0, 5, 0, 0, 2'b00, 0, 0, 1, 5, 1, 0, 0, 2'b01, 2'b00, 4'b0000, 3'b000, 0);
    tbl[5]  = mkv(0, 0, 0, 0, 5, 0, 2'b00, 0, 5, 1, 5, 1, 0, 0, 2'b00, 2'b10, 4'b0000, 3'b000, 0);
    tbl[6]  = mkv(0, 0, 0, 0, 5, 0, 2'b00, 0, 0, 1, 5, 1, 0, 0, 2'b00, 2'b01, 4'b0000, 3'b000, 0);
    tbl[7]  = mkv(0, 0, 0, 5, 5, 0, 2'b00, 0, 5, 0, 5, 1, 0, 0, 2'b01, 2'b01, 4'b0000, 3'b000, 0);
    tbl[8]  = mkv(0, 0, 0, 5, 5, 0, 2'b00, 0, 5, 0, 5, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 0);
    tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 0);
    tbl[10] = mkv(0, 0, 3, 0, 0, 3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b010, 0);
    tbl[11] = mkv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 0);
    tbl[12] = mkv(0, 7, 0, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b010, 0);
    tbl[13] = mkv(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 0);
    tbl[14] = mkv(0, 0, 3, 0, 0, 3, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 0);
    tbl[15] = mkv(0, 0, 3, 0, 0, 3, 2'b01, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b110, 0);
    tbl[16] = mkv(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b110, 0);

    for (int i = 0; i < 17; i++) step(tbl[i]);

    idle   = tbl[11];
    mstall = mkv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b1111, 3'b001, 0);

    // Single-cycle memory access: no stall.
    step(mkv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 4'b0000, 3'b000, 0));

    // Three-cycle wait with a branch pending; load-use and dropped request inside the wait.
    begin
      vec_t v;
      v = mstall; v.pcsrc = 1; step(v);
      v = mstall; v.pcsrc = 1; v.rsrc = 2'b01; v.rde = 3; v.rs2d = 3; step(v);
      v = mstall; v.pcsrc = 1; v.req = 0; step(v);
      step(mkv(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 4'b0000, 3'b110, 0));
      step(idle);
    end

    // Watchdog: one IDLE stall cycle, 15 WAIT cycles, then sticky TIMEOUT.
    step(mstall);
    for (int i = 0; i < 15; i++) step(mstall);
    tstall = mstall; tstall.tmo = 1; tstall.rdy = 1;
    for (int i = 0; i < 4; i++) step(tstall);
    tstall.req = 0;
    step(tstall);
    step(mkv(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 3'b111, 1));
    step(mkv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 0));

    // Reset in the second WAIT cycle returns the FSM to IDLE.
    step(mstall);
    step(mstall);
    step(mkv(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 3'b111, 0));
    step(mkv(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000, 0));
    step(idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
